// File: rtl/prng_32_checker.sv
// xorshift32 stream checker: locks onto the sequence and flags deviating words.
// Optional PRNG_CHECK_STICKY_EN makes error hold until reset.
module prng_32_checker #(
    parameter int LOCK_LEN   = 4,
    parameter int MISS_LIMIT = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             locked,
    output logic             error,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] match_count
);

    localparam int RUN_W  = $clog2(LOCK_LEN + 1);
    localparam int MISS_W = $clog2(MISS_LIMIT + 1);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_LEN - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);

    typedef enum logic [1:0] {
        UNLOCK = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [31:0]        exp_word, exp_nxt;
    logic [RUN_W-1:0]   run, run_nxt;
    logic [MISS_W-1:0]  miss, miss_nxt;
    logic               hit, miss_evt, match_evt;
    logic               locked_nxt, error_nxt;
    logic [CNT_W-1:0]   err_nxt, match_nxt;

    function automatic logic [31:0] xs_next(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    assign hit = (in_data == exp_word);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= UNLOCK;
            exp_word    <= '0;
            run         <= '0;
            miss        <= '0;
            locked      <= 1'b0;
            error       <= 1'b0;
            err_count   <= '0;
            match_count <= '0;
        end else begin
            state       <= state_nxt;
            exp_word    <= exp_nxt;
            run         <= run_nxt;
            miss        <= miss_nxt;
            locked      <= locked_nxt;
            error       <= error_nxt;
            err_count   <= err_nxt;
            match_count <= match_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        exp_nxt   = exp_word;
        run_nxt   = run;
        miss_nxt  = miss;
        if (in_valid) begin
            unique case (state)
                UNLOCK, ACQ: begin
                    if (state == ACQ && hit) begin
                        exp_nxt = xs_next(in_data);
                        run_nxt = run + RUN_W'(1);
                        if (run == RUN_LAST) begin
                            state_nxt = LOCKED;
                            miss_nxt  = '0;
                        end
                    end else if (in_data != 32'd0) begin
                        // seed from the word; zero is the fixed point of f
                        exp_nxt   = xs_next(in_data);
                        run_nxt   = RUN_W'(1);
                        state_nxt = ACQ;
                    end else begin
                        run_nxt   = '0;
                        state_nxt = UNLOCK;
                    end
                end
                LOCKED: begin
                    // free-wheel: never re-seed from a received word here
                    exp_nxt = xs_next(exp_word);
                    if (hit) begin
                        miss_nxt = '0;
                    end else if (miss == MISS_LAST) begin
                        miss_nxt  = '0;
                        run_nxt   = '0;
                        state_nxt = UNLOCK;
                    end else begin
                        miss_nxt = miss + MISS_W'(1);
                    end
                end
                default: state_nxt = UNLOCK;
            endcase
        end
    end

    always_comb begin
        miss_evt   = in_valid && (state == LOCKED) && !hit;
        match_evt  = in_valid && (state == LOCKED) && hit;
        locked_nxt = (state_nxt == LOCKED);
`ifdef PRNG_CHECK_STICKY_EN
        error_nxt  = error | miss_evt;
`else
        error_nxt  = miss_evt;
`endif
        err_nxt    = err_count;
        match_nxt  = match_count;
        if (miss_evt && err_count != '1)
            err_nxt = err_count + CNT_W'(1);
        if (match_evt && match_count != '1)
            match_nxt = match_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_prng_32_checker.sv
// Randomized + directed bench for prng_32_checker against a behavioural model.
// Counters run at CNT_W=4 so saturation is reachable.
module tb_prng_32_checker;

    localparam int LOCK_LEN   = 4;
    localparam int MISS_LIMIT = 3;
    localparam int CNT_W      = 4;
    localparam int SAT        = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic [31:0]      in_data = '0;
    logic             locked;
    logic             error;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] match_count;

    prng_32_checker #(
        .LOCK_LEN(LOCK_LEN),
        .MISS_LIMIT(MISS_LIMIT),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_data(in_data),
        .locked(locked),
        .error(error),
        .err_count(err_count),
        .match_count(match_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // reference model: tracking mode, predicted word, run/miss lengths
    int          m_mode;
    logic [31:0] m_pred;
    int          m_run, m_miss, m_errs, m_matches;
    bit          m_locked, m_error;
    logic [31:0] gen;

`ifdef PRNG_CHECK_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    function automatic logic [31:0] f(input logic [31:0] x);
        logic [63:0] t;
        t = {32'd0, x};
        t = (t ^ (t * 64'd8192)) % 64'h1_0000_0000;
        t = t ^ (t / 64'd131072);
        t = (t ^ (t * 64'd32)) % 64'h1_0000_0000;
        return t[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_seed(input logic [31:0] w);
        if (w != 0) begin
            m_pred = f(w);
            m_run  = 1;
            m_mode = 1;
        end else begin
            m_run  = 0;
            m_mode = 0;
        end
    endtask

    task automatic model_step(input bit v, input logic [31:0] w, input bit r);
        bit flag;
        flag = 1'b0;
        if (r) begin
            m_mode = 0; m_pred = 0; m_run = 0; m_miss = 0;
            m_errs = 0; m_matches = 0; m_locked = 0; m_error = 0;
            return;
        end
        if (v) begin
            if (m_mode == 2) begin
                if (w == m_pred) begin
                    m_miss = 0;
                    if (m_matches < SAT) m_matches++;
                end else begin
                    flag = 1'b1;
                    if (m_errs < SAT) m_errs++;
                    m_miss++;
                    if (m_miss == MISS_LIMIT) begin
                        m_mode = 0; m_locked = 0; m_run = 0; m_miss = 0;
                    end
                end
                m_pred = f(m_pred);
            end else if (m_mode == 1 && w == m_pred) begin
                m_pred = f(w);
                m_run++;
                if (m_run == LOCK_LEN) begin
                    m_mode = 2; m_locked = 1; m_miss = 0;
                end
            end else begin
                model_seed(w);
            end
        end
        m_error = STICKY ? (m_error | flag) : flag;
    endtask

    task automatic step(input bit v, input logic [31:0] w, input bit r);
        @(negedge clk);
        in_valid = v;
        in_data  = w;
        reset    = r;
        @(posedge clk);
        model_step(v, w, r);
        #1;
        check("locked", {31'd0, locked}, {31'd0, m_locked});
        check("error", {31'd0, error}, {31'd0, m_error});
        check("err_count", 32'(err_count), 32'(m_errs));
        check("match_count", 32'(match_count), 32'(m_matches));
    endtask

    task automatic good();
        step(1'b1, gen, 1'b0);
        gen = f(gen);
    endtask

    task automatic bad();
        step(1'b1, gen ^ 32'd1, 1'b0);
        gen = f(gen);
    endtask

    task automatic do_reset();
        step(1'b0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        int r;
        do_reset();
        check("reset_locked", {31'd0, locked}, 32'd0);
        check("reset_err", 32'(err_count), 32'd0);

        // clean lock
        gen = 32'd1;
        check("f1", f(32'd1), 32'h00042021);
        check("f2", f(32'h00042021), 32'h04080601);
        for (int i = 0; i < 3; i++) good();
        check("pre_lock", {31'd0, locked}, 32'd0);
        good();
        check("lock_4th", {31'd0, locked}, 32'd1);
        for (int i = 0; i < 8; i++) good();
        check("clean_matches", 32'(match_count), 32'd8);

        // gapped stream
        do_reset();
        gen = 32'd1;
        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(0, 5);
            for (int k = 0; k < r; k++) step(1'b0, $urandom, 1'b0);
            good();
        end
        check("gap_matches", 32'(match_count), 32'd8);
        check("gap_errs", 32'(err_count), 32'd0);

        // single corruption
        do_reset();
        gen = 32'd1;
        for (int i = 0; i < 5; i++) good();
        bad();
        check("corr_err", {31'd0, error}, 32'd1);
        check("corr_cnt", 32'(err_count), 32'd1);
        check("corr_lock", {31'd0, locked}, 32'd1);
        good();
        check("corr_match", 32'(match_count), 32'd2);

        // loss of lock and relock
        do_reset();
        gen = 32'd1;
        for (int i = 0; i < 4; i++) good();
        bad(); bad();
        check("loss_held", {31'd0, locked}, 32'd1);
        bad();
        check("loss_unlock", {31'd0, locked}, 32'd0);
        check("loss_err", {31'd0, error}, 32'd1);
        check("loss_cnt", 32'(err_count), 32'd3);
        gen = 32'h6a53d9f4;
        for (int i = 0; i < 4; i++) good();
        check("relock", {31'd0, locked}, 32'd1);
        check("relock_cnt", 32'(err_count), 32'd3);

        // zero and acquire edge cases
        do_reset();
        step(1'b1, 32'd0, 1'b0);
        step(1'b1, 32'd0, 1'b0);
        gen = 32'd1;
        good(); good();
        step(1'b1, 32'hdeadbeef, 1'b0);
        check("acq_noerr", 32'(err_count), 32'd0);
        gen = f(32'hdeadbeef);
        for (int i = 0; i < 3; i++) good();
        check("reseed_lock", {31'd0, locked}, 32'd1);
        step(1'b1, gen, 1'b1);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_match", 32'(match_count), 32'd0);

        // saturation with mismatches spaced below the miss limit
        do_reset();
        gen = 32'd7;
        for (int i = 0; i < 4; i++) good();
        for (int i = 0; i < 20; i++) begin
            bad();
            good();
        end
        check("sat_err", 32'(err_count), 32'(SAT));
        check("sat_lock", {31'd0, locked}, 32'd1);

        // random mix
        do_reset();
        gen = $urandom | 32'd1;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 15) step(1'b0, $urandom, 1'b0);
            else if (r < 25) begin
                step(1'b1, gen ^ (32'd1 << $urandom_range(0, 31)), 1'b0);
                gen = f(gen);
            end else if (r < 28) begin
                gen = $urandom;
                good();
            end else if (r < 29) step(1'b1, 32'd0, 1'b0);
            else if (r < 30) step(1'b0, 32'd0, 1'b1);
            else good();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/prng_32_checker.md
# prng_32_checker

Stream-side companion to `prng_32`. It consumes 32-bit words produced by a xorshift32 generator, locks onto the sequence, and flags any word that deviates from the predicted next value. It sits at the receive end of p-bit randomness links and in self-test paths to prove the generator and its transport are intact.

## Interface
- `LOCK_LEN`, default 4: consecutive correctly-predicted words needed to declare lock, counting the seeding word. Legal range is 2 or more.
- `MISS_LIMIT`, default 3: consecutive mismatches while locked that force loss of lock. Legal range is 1 or more.
- `CNT_W`, default 16: width of the error and match counters.

- `clk`  in  1: the single clock; everything is on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `in_valid`  in  1: `in_data` is a stream word this cycle.
- `in_data`  in  32: stream word.
- `locked`  out  1: the checker is tracking the sequence.
- `error`  out  1: mismatch indication while locked.
- `err_count`  out  CNT_W: mismatches seen while locked; saturates.
- `match_count`  out  CNT_W: matches seen while locked; saturates.

## Operation
- Next-state function f(x): x ^= x<<13; x ^= x>>17; x ^= x<<5. All shifts are logical and truncated to 32 bits.
- Internal state: FSM, expected word `exp[31:0]`, run counter, miss counter.
- The checker acts only in cycles with `in_valid`=1. Cycles with `in_valid`=0 change no state and no counter; gaps of any length are legal.
- Define "seed from w": if w≠0, then exp←f(w), run←1, state←ACQ. If w=0 (the fixed point of f), go to UNLOCK with run←0.
- **UNLOCK** (reset state): on a word w, seed from w.
- **ACQ**:
  - If w==exp: exp←f(w) and run←run+1. When run+1==LOCK_LEN, go to LOCKED, set `locked`←1 and clear the miss counter.
  - If w≠exp: seed from w. No error is raised and no counter changes.
- **LOCKED**:
  - If w==exp: exp←f(exp), miss←0, `match_count`+1.
  - If w≠exp: `error` asserted, `err_count`+1, exp←f(exp). The checker free-wheels and does not re-seed from w. miss←miss+1.
  - If miss+1==MISS_LIMIT: go to UNLOCK and set `locked`←0. The error for that word is still reported.
- Both counters saturate at all-ones and do not wrap. Neither counter is cleared on loss of lock; only `reset` clears them.

## Timing
- All outputs are registered. The response to a word sampled at edge N is visible after edge N, i.e. one-cycle latency.
- Reset values: `locked`=0, `error`=0, `err_count`=0, `match_count`=0. State is UNLOCK, exp=0, run=0, miss=0.
- Reset is synchronous and overrides everything. Asserting it mid-stream or mid-acquire discards lock and all counts at the next edge.
- `error` is a one-cycle pulse per mismatching word in non-sticky mode. Back-to-back mismatching words give back-to-back pulses.
- The fastest lock is LOCK_LEN consecutive valid cycles. `locked` rises on the edge that samples the LOCK_LEN-th word.
- On loss of lock, `locked` falls on the same edge that pulses `error` for the final miss. The next valid word re-seeds.
- f is purely combinational inside the one-cycle update; there is no internal pipelining.

## Configuration
- `PRNG_CHECK_STICKY_EN` defined: `error` is sticky. It sets on the first locked mismatch and holds 1 until `reset`, including across loss of lock and relock.
- `PRNG_CHECK_STICKY_EN` not defined: `error` is a one-cycle pulse per mismatching word, as specified above.
- Counter behaviour is identical in both builds.

## Test plan
- **Clean lock:** apply reset, then send 1, 0x00042021, 0x04080601, f(0x04080601), … continuously. Expect `locked`=1 after the 4th word, `error` never set, and `match_count`=N−4 after N words.
- **Gapped stream:** send the same sequence with `in_valid` low for 0–5 random cycles between words. Expect results identical to the clean-lock case.
- **Single corruption:** once locked, flip bit 0 of one word. Expect one `error` pulse, `err_count`=1, `locked` still 1, and the next correct word to count as a match.
- **Loss of lock:** once locked, send 3 consecutive wrong words. Expect 3 error pulses, `err_count`=3, and `locked`→0 with the 3rd pulse. A fresh 4-word run from seed 0x6a53d9f4 relocks, and `err_count` stays 3.
- **Zero/acquire edge cases:** send 0 (expect UNLOCK, no lock). Send 1, 0x00042021, then a wrong word w (expect re-seed from w, no error). Assert reset on the cycle after `locked` rises (expect all outputs 0 next cycle).
- **Saturation and sticky:** with CNT_W=4, force 20 locked mismatches spaced below MISS_LIMIT. Expect `err_count`=15. With `PRNG_CHECK_STICKY_EN`, expect `error` held at 1 until reset.
